// File: rtl/bitrev_stream_pkg.sv
// bitrev_stream_pkg
//   Shared definitions for the streaming bit-reversal peripheral:
//   register word offsets, CTRL/STATUS field positions, the reversal mode
//   enum, the engine state enum and the word reversal function.
package bitrev_stream_pkg;

    // Register word indices (byte address >> 2).
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_DIN    = 2;
    localparam int REG_DOUT   = 3;
    localparam int REG_IRQ_EN = 4;

    // CTRL fields
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_MODE_LSB = 2;
    localparam int CTRL_LEN_LSB  = 4;
    localparam int LEN_W         = 7;

    // STATUS fields
    localparam int ST_BUSY_BIT      = 0;
    localparam int ST_IN_FULL_BIT   = 1;
    localparam int ST_OUT_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT       = 3;
    localparam int ST_UDF_BIT       = 4;
    localparam int ST_IN_CNT_LSB    = 8;
    localparam int ST_OUT_CNT_LSB   = 12;

    // Widest supported word; the reversal function works on this width and
    // the caller keeps the low DATA_W bits.
    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        MODE_FULL        = 2'd0,  // out[i] = in[W-1-i]
        MODE_BYTE        = 2'd1,  // byte order swap
        MODE_BIT_IN_BYTE = 2'd2,  // reverse bits inside every byte
        MODE_LOW_LEN     = 2'd3   // reverse low LEN bits, upper bits zero
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } eng_state_e;

    // Reverse the low 'width' bits of din according to mode. Bits at and
    // above 'width' in the result are zero. LEN beyond width is clamped.
    function automatic logic [MAX_W-1:0] reverse_word(
        input logic [MAX_W-1:0] din,
        input int               width,
        input mode_e            mode,
        input logic [LEN_W-1:0] len
    );
        logic [MAX_W-1:0] r;
        int               n;
        r = '0;
        n = (int'(len) > width) ? width : int'(len);
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                case (mode)
                    MODE_FULL:        r[IDX_W'(i)] = din[IDX_W'(width - 1 - i)];
                    MODE_BYTE:        r[IDX_W'(i)] = din[IDX_W'((width / 8 - 1 - i / 8) * 8 + i % 8)];
                    MODE_BIT_IN_BYTE: r[IDX_W'(i)] = din[IDX_W'((i / 8) * 8 + 7 - i % 8)];
                    default:          r[IDX_W'(i)] = (i < n) ? din[IDX_W'(n - 1 - i)] : 1'b0;
                endcase
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_stream_fifo.sv
// bitrev_fifo
//   Synchronous FIFO of DEPTH words. A push while full and a pop while empty
//   are ignored. Push acceptance depends only on the count at the sampling
//   edge, so a full FIFO refuses a push even when a pop happens in the same
//   cycle. flush_i empties the FIFO and overrides push/pop.
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data
//   pop_i, rdata_o    read request and head-of-queue data
//   flush_i           discard all entries
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module bitrev_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Pointer wrap handles non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bitrev_stream.sv
// bitrev_stream
//   Streaming bit-reversal peripheral on an OBI-style register bus.
//   Software pushes words through DIN into an input FIFO; while EN is set
//   the engine pops one word per cycle, reverses it in the selected MODE
//   into a single stage register, and pushes the result into an output
//   FIFO that software drains through DOUT.
// Bus handshake: gnt_o mirrors req_i, so every request is accepted in the
//   cycle it is raised. rvalid_o pulses exactly one cycle after every grant
//   (reads and writes); rdata_o carries read data with rvalid_o, 0 otherwise.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, we_i, addr_i    request, write enable, byte address ([1:0] ignored)
//   wdata_i                write data
//   gnt_o, rvalid_o        grant, response valid
//   rdata_o                read data
//   irq_o                  registered level interrupt
module bitrev_stream
    import bitrev_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              irq_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Address decode
    logic [ADDR_W-3:0] word_addr;
    logic sel_ctrl, sel_status, sel_din, sel_dout, sel_irq_en;
    logic wr_en, rd_en, clr;
    logic unused_addr_bits;

    assign word_addr        = addr_i[ADDR_W-1:2];
    assign unused_addr_bits = ^addr_i[1:0];
    assign sel_ctrl   = (word_addr == (ADDR_W-2)'(REG_CTRL));
    assign sel_status = (word_addr == (ADDR_W-2)'(REG_STATUS));
    assign sel_din    = (word_addr == (ADDR_W-2)'(REG_DIN));
    assign sel_dout   = (word_addr == (ADDR_W-2)'(REG_DOUT));
    assign sel_irq_en = (word_addr == (ADDR_W-2)'(REG_IRQ_EN));
    assign wr_en = req_i & we_i;
    assign rd_en = req_i & ~we_i;
    assign clr   = wr_en & sel_ctrl & wdata_i[CTRL_CLR_BIT];

    assign gnt_o = req_i;

    // Registers
    logic                 en_q, en_d;
    mode_e                mode_q, mode_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [1:0]           irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0]    stage_data_q, stage_data_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 irq_q, irq_d;
    eng_state_e           state_q, state_d;

    // FIFOs
    logic [DATA_W-1:0] in_head, out_head;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CNT_W-1:0]  in_cnt, out_cnt;
    logic              in_push, eng_pop, out_push, out_pop;

    assign in_push  = wr_en & sel_din;
    assign out_push = stage_valid_q;
    assign out_pop  = rd_en & sel_dout & ~out_empty;

    bitrev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (in_push),
        .wdata_i (wdata_i),
        .pop_i   (eng_pop),
        .rdata_o (in_head),
        .flush_i (clr),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_cnt)
    );

    bitrev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (out_push),
        .wdata_i (stage_data_q),
        .pop_i   (out_pop),
        .rdata_o (out_head),
        .flush_i (clr),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_cnt)
    );

    // Reversal datapath on the input FIFO head.
    logic [MAX_W-1:0] rev_full;
    assign rev_full = reverse_word(MAX_W'(in_head), DATA_W, mode_q, len_q);

    if (DATA_W < MAX_W) begin : g_rev_pad
        logic unused_rev_hi;
        assign unused_rev_hi = ^rev_full[MAX_W-1:DATA_W];
    end

    // Room check: the stage word always has a reserved output slot, so the
    // stage can push unconditionally on the next cycle.
    logic [CNT_W:0] out_occ;
    logic           out_room;
    assign out_occ  = {1'b0, out_cnt} + (CNT_W+1)'(stage_valid_q);
    assign out_room = (out_occ < (CNT_W+1)'(DEPTH));

    // Engine FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Engine FSM: next state follows the EN bit being written this cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_d)  state_d = ST_RUN;
            ST_RUN:  if (!en_d) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine FSM: outputs. In IDLE nothing is popped but the stage still
    // drains to the output FIFO.
    always_comb begin
        eng_pop = 1'b0;
        case (state_q)
            ST_RUN:  eng_pop = ~in_empty & out_room & ~clr;
            default: eng_pop = 1'b0;
        endcase
    end

    // Register and flag next-state logic
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        if (wr_en && sel_ctrl) begin
            en_d   = wdata_i[CTRL_EN_BIT];
            mode_d = mode_e'(wdata_i[CTRL_MODE_LSB +: 2]);
            len_d  = wdata_i[CTRL_LEN_LSB +: LEN_W];
        end
        if (wr_en && sel_irq_en) begin
            irq_en_d = wdata_i[1:0];
        end

        ovf_d = ovf_q | (in_push & in_full);
        udf_d = udf_q | (rd_en & sel_dout & out_empty);
        if (clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        stage_valid_d = eng_pop;
        stage_data_d  = eng_pop ? rev_full[DATA_W-1:0] : stage_data_q;
    end

    // Read data, response and interrupt
    logic busy;
    assign busy = stage_valid_q | (en_q & ~in_empty);

    always_comb begin
        rvalid_d = req_i;
        rdata_d  = '0;
        if (rd_en) begin
            if (sel_ctrl)   rdata_d = DATA_W'({len_q, mode_q, 1'b0, en_q});
            if (sel_status) rdata_d = DATA_W'({4'(out_cnt), 4'(in_cnt), 3'b000,
                                               udf_q, ovf_q, out_empty, in_full, busy});
            if (sel_dout)   rdata_d = out_empty ? '0 : out_head;
            if (sel_irq_en) rdata_d = DATA_W'(irq_en_q);
        end
        irq_d = (irq_en_q[0] & ~out_empty) | (irq_en_q[1] & (ovf_q | udf_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q          <= 1'b0;
            mode_q        <= MODE_FULL;
            len_q         <= '0;
            irq_en_q      <= '0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            en_q          <= en_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
            irq_en_q      <= irq_en_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            irq_q         <= irq_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_bitrev_stream.sv
module tb_bitrev_stream;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_DIN    = 5'h08;
    localparam logic [4:0] A_DOUT   = 5'h0C;
    localparam logic [4:0] A_IRQ    = 5'h10;
    localparam logic [4:0] A_UNMAP  = 5'h14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sel = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic        req_a, req_b, gnt_a, gnt_b, rvalid_a, rvalid_b, irq_a, irq_b;
    logic [31:0] rdata_a, rdata_b;
    logic        rvalid, irq;
    logic [31:0] rdata;

    assign req_a  = req & ~sel;
    assign req_b  = req & sel;
    assign rvalid = sel ? rvalid_b : rvalid_a;
    assign rdata  = sel ? rdata_b : rdata_a;
    assign irq    = sel ? irq_b : irq_a;

    bitrev_stream #(.DATA_W(32), .DEPTH(4), .ADDR_W(5)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .irq_o(irq_a)
    );

    bitrev_stream #(.DATA_W(32), .DEPTH(2), .ADDR_W(5)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .irq_o(irq_b)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_rev(input int mode, input int len, input logic [31:0] x);
        logic [31:0] r, t;
        logic [63:0] m;
        int          n;
        case (mode)
            0: r = {<<{x}};
            1: r = {<<8{x}};
            2: begin t = {<<{x}}; r = {<<8{t}}; end
            default: begin
                n = (len > 32) ? 32 : len;
                if (n == 0) r = '0;
                else begin
                    m = {32'b0, x} & ((64'd1 << n) - 64'd1);
                    t = m[31:0];
                    t = {<<{t}};
                    r = t >> (32 - n);
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] st(input int busy, input int in_full, input int out_empty,
                                       input int ovf, input int udf, input int in_cnt, input int out_cnt);
        return 32'(busy) | (32'(in_full) << 1) | (32'(out_empty) << 2) | (32'(ovf) << 3) |
               (32'(udf) << 4) | (32'(in_cnt) << 8) | (32'(out_cnt) << 12);
    endfunction

    function automatic logic [31:0] ctrl_word(input int en, input int clr, input int mode, input int len);
        return 32'(en) | (32'(clr) << 1) | (32'(mode) << 2) | (32'(len) << 4);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0; we = 1'b0;
        end
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        v = rvalid;
        d = rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d; logic v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 || irq_a !== 1'b0 || irq_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rvalid=%b rdata=%h irq_a=%b irq_b=%b, expected 0", rvalid_a, rdata_a, irq_a, irq_b);
        end
        rst_n = 1'b1;
        idle(2);
        bus_rd(A_CTRL, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h v=%b, expected 00000000", d, v); end
        bus_rd(A_STATUS, d, v); n_vec++;
        if (v !== 1'b1 || d !== st(0,0,1,0,0,0,0)) begin n_err++; $display("FAIL reset_status: got %h, expected %h", d, st(0,0,1,0,0,0,0)); end
        bus_rd(A_IRQ, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL reset_irq_en: got %h, expected 0", d); end
        idle(1); n_vec++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL idle_resp: rvalid=%b rdata=%h, expected 0/0", rvalid, rdata); end
    endtask

    task automatic test_regmap();
        logic [31:0] d; logic v;
        bus_wr(A_IRQ, 32'hFFFF_FFFF);
        bus_rd(A_IRQ, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h3) begin n_err++; $display("FAIL irq_en_rw: got %h, expected 00000003", d); end
        bus_wr(A_IRQ, 32'h0);
        bus_wr(A_UNMAP, 32'hDEAD_BEEF);
        bus_rd(A_UNMAP, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h, expected 0", d); end
        bus_rd(A_DIN, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL din_rd: got %h, expected 0", d); end
        bus_wr(A_STATUS, 32'hFFFF_FFFF);
        bus_rd(A_STATUS, d, v); n_vec++;
        if (v !== 1'b1 || d !== st(0,0,1,0,0,0,0)) begin n_err++; $display("FAIL status_ro: got %h, expected %h", d, st(0,0,1,0,0,0,0)); end
        bus_wr(A_CTRL, ctrl_word(0, 1, 2, 9));
        bus_rd(A_CTRL, d, v); n_vec++;
        if (v !== 1'b1 || d !== ctrl_word(0, 0, 2, 9)) begin n_err++; $display("FAIL ctrl_clr_rd0: got %h, expected %h", d, ctrl_word(0, 0, 2, 9)); end
    endtask

    task automatic test_modes_directed();
        int          mode_t[7] = '{0, 0, 1, 2, 3, 3, 3};
        int          len_t[7]  = '{0, 0, 0, 0, 3, 3, 0};
        logic [31:0] din_t[7]  = '{32'h0000_0001, 32'hF000_0000, 32'h1234_5678, 32'h0102_0304,
                                   32'h0000_0006, 32'hFFFF_FFF1, 32'hFFFF_FFFF};
        logic [31:0] exp_t[7]  = '{32'h8000_0000, 32'h0000_000F, 32'h7856_3412, 32'h8040_C020,
                                   32'h0000_0003, 32'h0000_0004, 32'h0000_0000};
        logic [31:0] d; logic v;
        for (int i = 0; i < 7; i++) begin
            bus_wr(A_CTRL, ctrl_word(1, 0, mode_t[i], len_t[i]));
            bus_wr(A_DIN, din_t[i]);
            idle(4);
            bus_rd(A_DOUT, d, v); n_vec++;
            if (v !== 1'b1 || d !== exp_t[i]) begin
                n_err++;
                $display("FAIL directed[%0d] mode%0d: in %h got %h, expected %h", i, mode_t[i], din_t[i], d, exp_t[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] d, x; logic v;
        bus_wr(A_CTRL, ctrl_word(1, 0, 0, 0));
        idle(2);
        x = $urandom;
        bus_wr(A_DIN, x);                 // granted cycle t
        idle(1);                          // t+1: popped
        bus_rd(A_STATUS, d, v); n_vec++;  // t+2: result only in stage
        if (d !== st(1,0,1,0,0,0,0)) begin n_err++; $display("FAIL latency_t2: got %h, expected %h", d, st(1,0,1,0,0,0,0)); end
        bus_rd(A_DOUT, d, v); n_vec++;
        if (v !== 1'b1 || d !== ref_rev(0, 0, x)) begin n_err++; $display("FAIL latency_data1: got %h, expected %h", d, ref_rev(0, 0, x)); end
        x = $urandom;
        bus_wr(A_DIN, x);                 // granted cycle t
        idle(2);
        bus_rd(A_STATUS, d, v); n_vec++;  // t+3: visible in output FIFO
        if (d !== st(0,0,0,0,0,0,1)) begin n_err++; $display("FAIL latency_t3: got %h, expected %h", d, st(0,0,0,0,0,0,1)); end
        bus_rd(A_DOUT, d, v); n_vec++;
        if (v !== 1'b1 || d !== ref_rev(0, 0, x)) begin n_err++; $display("FAIL latency_data2: got %h, expected %h", d, ref_rev(0, 0, x)); end
    endtask

    task automatic test_random();
        logic [31:0] d, x, e; logic v;
        int mode, len, n;
        for (int b = 0; b < 20; b++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(0, 40);
            n    = $urandom_range(1, 6);
            bus_wr(A_CTRL, ctrl_word(1, 0, mode, len));
            for (int k = 0; k < n; k++) begin
                x = $urandom;
                bus_wr(A_DIN, x);
                exp_q.push_back(ref_rev(mode, len, x));
            end
            idle(10);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                bus_rd(A_DOUT, d, v); n_vec++;
                if (v !== 1'b1 || d !== e) begin
                    n_err++;
                    $display("FAIL random[%0d] mode%0d len%0d: got %h, expected %h", b, mode, len, d, e);
                end
            end
        end
    endtask

    task automatic test_ovf_udf_irq_clr();
        logic [31:0] d, x, e; logic v;
        bus_wr(A_CTRL, ctrl_word(0, 0, 1, 0));
        bus_wr(A_IRQ, 32'h2);
        for (int k = 0; k < 5; k++) begin
            x = $urandom;
            bus_wr(A_DIN, x);
            if (k < 4) exp_q.push_back(ref_rev(1, 0, x));
        end
        idle(3); n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq: irq=%b, expected 1", irq); end
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(0,1,1,1,0,4,0)) begin n_err++; $display("FAIL ovf_status: got %h, expected %h", d, st(0,1,1,1,0,4,0)); end
        bus_wr(A_CTRL, ctrl_word(1, 0, 1, 0));
        idle(8);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            bus_rd(A_DOUT, d, v); n_vec++;
            if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h, expected %h", k, d, e); end
        end
        bus_rd(A_DOUT, d, v); n_vec++;
        if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL udf_rdata: got %h, expected 0", d); end
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(0,0,1,1,1,0,0)) begin n_err++; $display("FAIL udf_status: got %h, expected %h", d, st(0,0,1,1,1,0,0)); end
        bus_wr(A_CTRL, ctrl_word(1, 1, 1, 0));
        idle(2);
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(0,0,1,0,0,0,0)) begin n_err++; $display("FAIL clr_status: got %h, expected %h", d, st(0,0,1,0,0,0,0)); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq: irq=%b, expected 0", irq); end
        bus_rd(A_CTRL, d, v); n_vec++;
        if (d !== ctrl_word(1, 0, 1, 0)) begin n_err++; $display("FAIL clr_keeps_ctrl: got %h, expected %h", d, ctrl_word(1, 0, 1, 0)); end
        bus_wr(A_IRQ, 32'h1);
        x = $urandom;
        bus_wr(A_DIN, x);
        idle(4); n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_not_empty: irq=%b, expected 1", irq); end
        bus_rd(A_DOUT, d, v); n_vec++;
        if (d !== ref_rev(1, 0, x)) begin n_err++; $display("FAIL irq_word: got %h, expected %h", d, ref_rev(1, 0, x)); end
        idle(2); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: irq=%b, expected 0", irq); end
        bus_wr(A_IRQ, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, x, e; logic v;
        idle(1);
        sel = 1'b1;
        bus_wr(A_CTRL, ctrl_word(1, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            x = $urandom;
            bus_wr(A_DIN, x);
            exp_q.push_back(ref_rev(0, 0, x));
        end
        idle(6);
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(1,1,0,0,0,2,2)) begin n_err++; $display("FAIL b2b_stall_status: got %h, expected %h", d, st(1,1,0,0,0,2,2)); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            bus_rd(A_DOUT, d, v); n_vec++;
            if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL b2b_order[%0d]: got %h, expected %h", k, d, e); end
        end
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(0,0,1,0,0,0,0)) begin n_err++; $display("FAIL b2b_final_status: got %h, expected %h", d, st(0,0,1,0,0,0,0)); end
        idle(1);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        bus_wr(A_CTRL, ctrl_word(1, 0, 2, 0));
        bus_wr(A_DIN, $urandom);
        bus_wr(A_DIN, $urandom);
        bus_rd(A_STATUS, d, v);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_resp: rvalid=%b rdata=%h, expected 0", rvalid, rdata); end
        bus_rd(A_STATUS, d, v); n_vec++;
        if (d !== st(0,0,1,0,0,0,0)) begin n_err++; $display("FAIL rst_mid_status: got %h, expected %h", d, st(0,0,1,0,0,0,0)); end
        bus_rd(A_CTRL, d, v); n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_ctrl: got %h, expected 0", d); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_regmap();
        test_modes_directed();
        test_latency();
        test_random();
        test_ovf_udf_irq_clr();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
